dmem_bus_ctrl: RTL
==================

// Module: dmem_bus_ctrl
// PURPOSE
// - Data-side memory controller sitting directly downstream of the single-cycle datapath.
// - Consumes ALUResult (address), WriteData, MemWrite, MemRead; returns ReadData to the datapath.
// - Decodes addresses to on-chip sync RAM or a req/ack peripheral bus.
// - Produces Stall so the core holds PC/regfile while a slow access completes.
// PARAMETERS
// - RAM_AW    10             RAM word-address width (RAM = 2**RAM_AW words)
// - RAM_BASE  32'h0000_0000  RAM base address; aligned to RAM size
// - PER_BASE  32'h4000_0000  peripheral window base; window = 64 KiB
// - TIMEOUT   16             max cycles waiting for per_ack before a bus error (>=2)
// PORTS
// - clk        in   1       system clock, rising edge
// - reset      in   1       asynchronous, ACTIVE-LOW reset (0 = reset)
// - MemRead    in   1       datapath load request
// - MemWrite   in   1       datapath store request
// - ALUResult  in   32      byte address; [1:0] ignored (word accesses only)
// - WriteData  in   32      store data
// - ReadData   out  32      load data; valid only in the cycle where Stall=0 and access done
// - Stall      out  1       1 = hold processor state this cycle
// - BusErr     out  1       one-cycle pulse: timeout or unmapped access
// - ram_en     out  1       RAM cycle enable
// - ram_we     out  1       RAM write enable
// - ram_addr   out  RAM_AW  RAM word address = ALUResult[RAM_AW+1:2]
// - ram_wdata  out  32      RAM write data
// - ram_rdata  in   32      RAM read data, 1-cycle latency after ram_en
// - per_req    out  1       peripheral request; held until per_ack
// - per_we     out  1       peripheral write; registered with per_req
// - per_addr   out  16      peripheral byte offset; registered
// - per_wdata  out  32      peripheral write data; registered
// - per_ack    in   1       peripheral completion, 1-cycle pulse
// - per_rdata  in   32      valid when per_ack=1
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; per_req, per_we, BusErr, Stall = 0;
//   per_addr, per_wdata, rdata_q, timeout count = 0. Reset mid-access drops per_req at once.
// - Access = MemRead|MemWrite. If both are 1, treat as write.
// - FSM states: IDLE, RAM_RD, PER_WAIT, DONE.
// - IDLE, no access: Stall=0, ReadData=0.
// - IDLE, RAM write: ram_en=ram_we=1 combinationally, Stall=0, zero wait; stay IDLE.
// - IDLE, RAM read: ram_en=1, Stall=1 -> RAM_RD.
//   - RAM_RD: Stall=0, ReadData=ram_rdata -> IDLE. Total latency: 1 stall cycle.
// - IDLE, peripheral access: Stall=1.
//   - Register per_req=1, per_we, per_addr, per_wdata; clear counter -> PER_WAIT.
// - PER_WAIT: Stall=1; counter increments each cycle.
//   - per_ack=1: capture per_rdata into rdata_q; per_req=0 -> DONE.
//   - counter==TIMEOUT-1 and no ack: per_req=0, rdata_q=32'h0, set err_q -> DONE.
//   - Ack and timeout on the same cycle: the ack wins, with no error.
// - DONE: Stall=0, ReadData=rdata_q, BusErr=err_q -> IDLE.
//   - The core's address is still present in DONE; it must NOT launch a new access.
// - Unmapped address in IDLE with access: no stall, ReadData=0, write dropped,
//   BusErr=1 that cycle.
// - Late per_ack arriving in IDLE: ignored.
// - Stall and ram_en are combinational from state and inputs; all per_* outputs are registered.
// STRUCTURE
// - dmem_pkg:
//   - typedef enum logic [1:0] dmem_state_t {IDLE, RAM_RD, PER_WAIT, DONE}
//   - localparams PER_MASK=32'hFFFF_0000 and ERR_RDATA=32'h0
// - Sub-module dmem_addr_decode: combinational; ALUResult -> {hit_ram, hit_per, unmapped}.
// - Top: FSM, timeout counter ($clog2(TIMEOUT) bits), capture registers.
// TESTING
// - RAM store 0xA5A5_0001 @0x10, then load @0x10 -> store Stall=0; load Stall=1 for one cycle,
//   then ReadData=0xA5A5_0001.
// - Peripheral load @0x4000_0008, ack after 3 cycles with 0x1234 -> Stall high 4 cycles;
//   DONE ReadData=0x1234; per_addr=0x0008.
// - No ack, TIMEOUT=16 -> per_req drops after 16 cycles; DONE ReadData=0, BusErr pulses once.
// - Unmapped load @0x8000_0000 -> Stall=0, ReadData=0, BusErr=1 for exactly one cycle.
// - Assert reset low during PER_WAIT -> per_req=0 and Stall=0 immediately;
//   after release, a late per_ack is ignored.
// - MemRead=MemWrite=1 to RAM @0x4 -> write performed (ram_we=1), no stall.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, RAM_RD, PER_WAIT, DONE} dmem_state_t;

    localparam logic [31:0] PER_MASK  = 32'hFFFF_0000;
    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/dmem_addr_decode.sv
// Combinational address decoder: classifies a byte address as RAM, peripheral window or unmapped.
module dmem_addr_decode
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_AW   = 10,
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter logic [31:0] PER_BASE = 32'h4000_0000
) (
    input  logic [31:0] addr,
    output logic        hit_ram,
    output logic        hit_per,
    output logic        unmapped
);

    // RAM spans 2**RAM_AW words, i.e. 2**(RAM_AW+2) bytes, aligned to its own size.
    localparam logic [31:0] RAM_MASK = ~((32'd1 << (RAM_AW + 2)) - 32'd1);

    always_comb begin
        hit_ram  = ((addr & RAM_MASK) == RAM_BASE);
        hit_per  = !hit_ram && ((addr & PER_MASK) == PER_BASE);
        unmapped = !hit_ram && !hit_per;
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-side memory controller: routes core loads/stores to sync RAM or a req/ack peripheral bus,
// stalling the core while slow accesses complete.
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_AW   = 10,
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter logic [31:0] PER_BASE = 32'h4000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              BusErr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              per_req,
    output logic              per_we,
    output logic [15:0]       per_addr,
    output logic [31:0]       per_wdata,
    input  logic              per_ack,
    input  logic [31:0]       per_rdata
);

    localparam int unsigned         CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic hit_ram, hit_per, unmapped;
    logic access, launch_per;

    dmem_addr_decode #(
        .RAM_AW   (RAM_AW),
        .RAM_BASE (RAM_BASE),
        .PER_BASE (PER_BASE)
    ) u_decode (
        .addr     (ALUResult),
        .hit_ram  (hit_ram),
        .hit_per  (hit_per),
        .unmapped (unmapped)
    );

    assign access     = MemRead | MemWrite;
    assign launch_per = (state == IDLE) && access && hit_per;
    assign ram_addr   = ALUResult[RAM_AW+1:2];
    assign ram_wdata  = WriteData;

    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        BusErr    = 1'b0;
        ReadData  = 32'h0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (hit_ram) begin
                        ram_en = 1'b1;
                        // A simultaneous read+write is treated as a write.
                        if (MemWrite) begin
                            ram_we = 1'b1;
                        end else begin
                            Stall     = 1'b1;
                            state_nxt = RAM_RD;
                        end
                    end else if (hit_per) begin
                        Stall     = 1'b1;
                        state_nxt = PER_WAIT;
                    end else if (unmapped) begin
                        BusErr = 1'b1;
                    end
                end
            end
            RAM_RD: begin
                ReadData  = ram_rdata;
                state_nxt = IDLE;
            end
            PER_WAIT: begin
                Stall = 1'b1;
                if (per_ack || (cnt == CNT_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Address is still on the bus here; returning to IDLE without re-decoding it.
                ReadData  = rdata_q;
                BusErr    = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs stay quiet while reset is held, even with a request still presented.
        if (!reset) begin
            Stall    = 1'b0;
            BusErr   = 1'b0;
            ReadData = 32'h0;
            ram_en   = 1'b0;
            ram_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            per_req   <= 1'b0;
            per_we    <= 1'b0;
            per_addr  <= 16'h0;
            per_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (launch_per) begin
                per_req   <= 1'b1;
                per_we    <= MemWrite;
                per_addr  <= ALUResult[15:0];
                per_wdata <= WriteData;
                err_q     <= 1'b0;
                cnt       <= '0;
            end else if (state == PER_WAIT) begin
                cnt <= cnt + 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (per_ack) begin
                    rdata_q <= per_rdata;
                    per_req <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    rdata_q <= ERR_RDATA;
                    per_req <= 1'b0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

endmodule
